// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Two-entry elastic pipeline register carrying LANES lanes of DATA_W-bit
//   payload per beat. The head register (H) drives the outputs. The skid
//   register (S) absorbs one extra beat so that in_ready depends only on
//   registered state and flush, and never on out_ready.
//
// Ports
//   clk          stage clock
//   rst          asynchronous active-high reset, clears all held beats
//   flush        synchronous kill of all held beats, blocks acceptance
//   in_valid     upstream beat present
//   in_ready     buffer can accept a beat this cycle
//   in_lane_vld  per-lane valid of the incoming beat
//   in_data      lane-packed incoming payload, lane 0 in the LSBs
//   out_valid    head beat present
//   out_ready    downstream consumes the head this cycle
//   out_lane_vld per-lane valid of the head beat
//   out_data     head payload
//   out_count    number of entries held (0..2)
//
// State | meaning
// EMPTY | nothing held, H and S zero
// ONE   | H valid, S zero
// FULL  | H and S valid, S is the younger beat
module pipe_stage_buf #(
  parameter int DATA_W        = 32,
  parameter int LANES         = 2,
  parameter bit SQUASH_BUBBLE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_vld,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_vld,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              out_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [LANES*DATA_W-1:0]   r_h_data;
  logic [LANES-1:0]          r_h_lv;
  logic [LANES*DATA_W-1:0]   r_s_data;
  logic [LANES-1:0]          r_s_lv;

  state_t                    w_state_nxt;
  logic [LANES*DATA_W-1:0]   w_h_data_nxt;
  logic [LANES-1:0]          w_h_lv_nxt;
  logic [LANES*DATA_W-1:0]   w_s_data_nxt;
  logic [LANES-1:0]          w_s_lv_nxt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_store;

  assign in_ready   = (r_state != ST_FULL) & ~flush;
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  // An accepted all-bubble beat completes its handshake but is not stored.
  assign w_store    = w_in_fire & (!SQUASH_BUBBLE | (|in_lane_vld));

  // Invalid entries are kept at zero, so H can drive the outputs directly.
  assign out_data     = r_h_data;
  assign out_lane_vld = r_h_lv;

  always_comb begin
    out_count = 2'd0;
    case (r_state)
      ST_ONE:  out_count = 2'd1;
      ST_FULL: out_count = 2'd2;
      default: out_count = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_h_data_nxt = r_h_data;
    w_h_lv_nxt   = r_h_lv;
    w_s_data_nxt = r_s_data;
    w_s_lv_nxt   = r_s_lv;
    if (flush) begin
      w_state_nxt  = ST_EMPTY;
      w_h_data_nxt = '0;
      w_h_lv_nxt   = '0;
      w_s_data_nxt = '0;
      w_s_lv_nxt   = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_store) begin
            w_state_nxt  = ST_ONE;
            w_h_data_nxt = in_data;
            w_h_lv_nxt   = in_lane_vld;
          end
        end
        ST_ONE: begin
          if (w_store && w_out_fire) begin
            w_h_data_nxt = in_data;
            w_h_lv_nxt   = in_lane_vld;
          end else if (w_out_fire) begin
            w_state_nxt  = ST_EMPTY;
            w_h_data_nxt = '0;
            w_h_lv_nxt   = '0;
          end else if (w_store) begin
            w_state_nxt  = ST_FULL;
            w_s_data_nxt = in_data;
            w_s_lv_nxt   = in_lane_vld;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the pop can happen.
          if (w_out_fire) begin
            w_state_nxt  = ST_ONE;
            w_h_data_nxt = r_s_data;
            w_h_lv_nxt   = r_s_lv;
            w_s_data_nxt = '0;
            w_s_lv_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt  = ST_EMPTY;
          w_h_data_nxt = '0;
          w_h_lv_nxt   = '0;
          w_s_data_nxt = '0;
          w_s_lv_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_h_data <= '0;
      r_h_lv   <= '0;
      r_s_data <= '0;
      r_s_lv   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_h_data <= w_h_data_nxt;
      r_h_lv   <= w_h_lv_nxt;
      r_s_data <= w_s_data_nxt;
      r_s_lv   <= w_s_lv_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf
//   Directed vector table for the listed scenarios, a hand-written async
//   reset sequence, then random traffic checked against a queue model.
module tb_pipe_stage_buf;

  localparam int DW = 32;
  localparam int LN = 2;
  localparam int PW = DW * LN;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [LN-1:0] in_lane_vld;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [LN-1:0] out_lane_vld;
  logic [PW-1:0] out_data;
  logic [1:0]    out_count;

  int n_cmp;
  int n_err;

  pipe_stage_buf #(.DATA_W(DW), .LANES(LN), .SQUASH_BUBBLE(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_lane_vld  (in_lane_vld),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane_vld (out_lane_vld),
    .out_data     (out_data),
    .out_count    (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          iv;
    logic [LN-1:0] lv;
    logic [PW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          e_ov;
    logic [1:0]    e_cnt;
    logic          e_ir;
    logic [LN-1:0] e_lv;
    logic [PW-1:0] e_d;
  } vec_t;

  vec_t tv[22];

  typedef struct {
    logic [LN-1:0] lv;
    logic [PW-1:0] d;
  } beat_t;

  beat_t q[$];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: act=%h req=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [1:0] cnt, input logic ir,
                         input logic [LN-1:0] lv, input logic [PW-1:0] d);
    chk({tag, ".out_valid"},    PW'(out_valid),    PW'(ov));
    chk({tag, ".out_count"},    PW'(out_count),    PW'(cnt));
    chk({tag, ".in_ready"},     PW'(in_ready),     PW'(ir));
    chk({tag, ".out_lane_vld"}, PW'(out_lane_vld), PW'(lv));
    chk({tag, ".out_data"},     out_data,          d);
  endtask

  function automatic vec_t mk(input logic iv, input logic [LN-1:0] lv, input logic [PW-1:0] d,
                              input logic ordy, input logic fl, input logic e_ov,
                              input logic [1:0] e_cnt, input logic e_ir,
                              input logic [LN-1:0] e_lv, input logic [PW-1:0] e_d);
    vec_t v;
    v.iv = iv; v.lv = lv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_lv = e_lv; v.e_d = e_d;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [LN-1:0] lv, input logic [PW-1:0] d,
                       input logic ordy, input logic fl);
    in_valid = iv; in_lane_vld = lv; in_data = d; out_ready = ordy; flush = fl;
  endtask

  localparam logic [PW-1:0] P12 = {32'h2222_2222, 32'h1111_1111};
  localparam logic [PW-1:0] P34 = {32'h4444_4444, 32'h3333_3333};
  localparam logic [PW-1:0] PA  = 64'hA;
  localparam logic [PW-1:0] PB  = 64'hB;
  localparam logic [PW-1:0] PC  = 64'hC;
  localparam logic [PW-1:0] PDE = 64'hDEAD;
  localparam logic [PW-1:0] PD  = 64'hD;
  localparam logic [PW-1:0] PE  = 64'hE;
  localparam logic [PW-1:0] PF  = 64'hF;
  localparam logic [PW-1:0] Z   = '0;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    //             iv  lv     data ordy fl   ov  cnt  ir  e_lv   e_d
    tv[0]  = mk(1, 2'b11, P12, 1, 0,  0, 2'd0, 1, 2'b00, Z);
    tv[1]  = mk(1, 2'b11, P34, 1, 0,  1, 2'd1, 1, 2'b11, P12);
    tv[2]  = mk(0, 2'b00, Z,   1, 0,  1, 2'd1, 1, 2'b11, P34);
    tv[3]  = mk(0, 2'b00, Z,   1, 0,  0, 2'd0, 1, 2'b00, Z);
    tv[4]  = mk(1, 2'b01, PA,  0, 0,  0, 2'd0, 1, 2'b00, Z);
    tv[5]  = mk(1, 2'b01, PB,  0, 0,  1, 2'd1, 1, 2'b01, PA);
    tv[6]  = mk(0, 2'b00, Z,   0, 0,  1, 2'd2, 0, 2'b01, PA);
    tv[7]  = mk(0, 2'b00, Z,   1, 0,  1, 2'd2, 0, 2'b01, PA);
    tv[8]  = mk(0, 2'b00, Z,   1, 0,  1, 2'd1, 1, 2'b01, PB);
    tv[9]  = mk(0, 2'b00, Z,   0, 0,  0, 2'd0, 1, 2'b00, Z);
    tv[10] = mk(1, 2'b01, PA,  0, 0,  0, 2'd0, 1, 2'b00, Z);
    tv[11] = mk(1, 2'b01, PB,  0, 0,  1, 2'd1, 1, 2'b01, PA);
    tv[12] = mk(1, 2'b01, PC,  0, 1,  1, 2'd2, 0, 2'b01, PA);
    tv[13] = mk(0, 2'b00, Z,   1, 0,  0, 2'd0, 1, 2'b00, Z);
    tv[14] = mk(0, 2'b00, Z,   0, 0,  0, 2'd0, 1, 2'b00, Z);
    tv[15] = mk(1, 2'b00, PDE, 0, 0,  0, 2'd0, 1, 2'b00, Z);
    tv[16] = mk(0, 2'b00, Z,   0, 0,  0, 2'd0, 1, 2'b00, Z);
    tv[17] = mk(1, 2'b01, PD,  0, 0,  0, 2'd0, 1, 2'b00, Z);
    tv[18] = mk(1, 2'b01, PE,  1, 0,  1, 2'd1, 1, 2'b01, PD);
    tv[19] = mk(0, 2'b00, Z,   0, 0,  1, 2'd1, 1, 2'b01, PE);
    tv[20] = mk(0, 2'b00, Z,   1, 0,  1, 2'd1, 1, 2'b01, PE);
    tv[21] = mk(0, 2'b00, Z,   0, 0,  0, 2'd0, 1, 2'b00, Z);

    #1;
    chk_all("reset", 1'b0, 2'd0, 1'b1, '0, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tv[i].iv, tv[i].lv, tv[i].d, tv[i].ordy, tv[i].fl);
      #1;
      chk_all($sformatf("vec%0d", i), tv[i].e_ov, tv[i].e_cnt, tv[i].e_ir, tv[i].e_lv, tv[i].e_d);
    end

    // Async reset while FULL: outputs must clear before the next edge.
    @(negedge clk); drive(1'b1, 2'b01, PA, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 2'b01, PB, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 2'b00, Z, 1'b0, 1'b0);
    #1;
    chk_all("pre_rst_full", 1'b1, 2'd2, 1'b0, 2'b01, PA);
    #1 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 2'd0, 1'b1, '0, '0);
    @(negedge clk); rst = 1'b0;
    drive(1'b1, 2'b01, PF, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 2'b00, Z, 1'b1, 1'b0);
    #1;
    chk_all("post_rst_F", 1'b1, 2'd1, 1'b1, 2'b01, PF);
    @(negedge clk); drive(1'b0, 2'b00, Z, 1'b0, 1'b0);
    #1;
    chk_all("post_rst_empty", 1'b0, 2'd0, 1'b1, '0, '0);

    // Random traffic against a FIFO-queue model; state is EMPTY here.
    q.delete();
    for (int c = 0; c < 2000; c++) begin
      logic          r_iv, r_or, r_fl, e_ir, e_ov;
      logic [LN-1:0] r_lv;
      logic [PW-1:0] r_d;
      beat_t         b;
      @(negedge clk);
      r_iv = ($urandom_range(0, 3) != 0);
      r_lv = LN'($urandom_range(0, 3));
      r_d  = {$urandom, $urandom};
      r_or = ($urandom_range(0, 2) != 0);
      r_fl = ($urandom_range(0, 19) == 0);
      drive(r_iv, r_lv, r_d, r_or, r_fl);
      #1;
      e_ir = (q.size() < 2) && !r_fl;
      e_ov = (q.size() > 0);
      if (e_ov) chk_all($sformatf("rnd%0d", c), 1'b1, 2'(q.size()), e_ir, q[0].lv, q[0].d);
      else      chk_all($sformatf("rnd%0d", c), 1'b0, 2'd0, e_ir, '0, '0);
      if (r_fl) begin
        q.delete();
      end else begin
        if (e_ov && r_or) void'(q.pop_front());
        if (r_iv && e_ir && (r_lv != '0)) begin
          b.lv = r_lv;
          b.d  = r_d;
          q.push_back(b);
        end
      end
    end

    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
